// File: rtl/ip_match_sched.sv
// Time-multiplexes one ip_comparator across a table of flagged IPv4 addresses:
// buffers a packet, then clears/loads/replays/flushes the comparator per enabled entry.
module ip_match_sched #(
    parameter int NUM_IPS     = 4,
    parameter int BUF_DEPTH   = 16,
    parameter int CMP_LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_IPS)-1:0] cfg_idx,
    input  logic [31:0]                cfg_ip,
    input  logic                       cfg_en,
    input  logic                       pkt_valid,
    input  logic [31:0]                pkt_data,
    input  logic                       pkt_last,
    output logic                       pkt_ready,
    output logic                       cmp_clear,
    output logic [31:0]                cmp_flagged_ip,
    output logic [31:0]                cmp_data_in,
    input  logic                       cmp_match,
    output logic                       res_valid,
    output logic                       res_hit,
    output logic [$clog2(NUM_IPS)-1:0] res_idx,
    output logic                       res_ovf,
    input  logic                       res_ready
);

    localparam int IDX_W = $clog2(NUM_IPS);
    localparam int SP_W  = IDX_W + 1;
    localparam int BUF_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = BUF_W + 1;
    localparam int DRN_W = $clog2(CMP_LATENCY + 2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SELECT  = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_REPLAY  = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_REPORT  = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        ip_tbl_r [NUM_IPS];
    logic [NUM_IPS-1:0] en_tbl_r;
    logic [31:0]        pkt_buf_r [BUF_DEPTH];
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   rd_ptr_r;
    logic [SP_W-1:0]    scan_ptr_r;
    logic [IDX_W-1:0]   cur_idx_r;
    logic [DRN_W-1:0]   drain_cnt_r;
    logic               ovf_r;
    logic [31:0]        flagged_ip_r;
    logic               res_hit_r;
    logic [IDX_W-1:0]   res_idx_r;
    logic               res_ovf_r;

    logic               xfer_s;
    logic               found_s;
    logic               cand_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               last_word_s;
    logic               drain_done_s;
    logic               last_entry_s;

    assign pkt_ready      = (state_r == ST_IDLE) || (state_r == ST_CAPTURE);
    assign xfer_s         = pkt_valid && pkt_ready;
    assign last_word_s    = (rd_ptr_r == (count_r - CNT_W'(1)));
    assign drain_done_s   = (drain_cnt_r == DRN_W'(CMP_LATENCY));
    assign last_entry_s   = (cur_idx_r == IDX_W'(NUM_IPS - 1));

    assign cmp_clear      = (state_r == ST_CLEAR);
    assign cmp_data_in    = (state_r == ST_REPLAY) ? pkt_buf_r[rd_ptr_r[BUF_W-1:0]] : 32'h0000_0000;
    assign cmp_flagged_ip = flagged_ip_r;
    assign res_valid      = (state_r == ST_REPORT);
    assign res_hit        = res_hit_r;
    assign res_idx        = res_idx_r;
    assign res_ovf        = res_ovf_r;

    // Lowest enabled entry at or above the scan pointer (descending loop so the lowest wins).
    always_comb begin
        found_s   = 1'b0;
        cand_s    = 1'b0;
        sel_idx_s = '0;
        for (int i = NUM_IPS - 1; i >= 0; i--) begin
            cand_s    = en_tbl_r[i] && (SP_W'(i) >= scan_ptr_r);
            sel_idx_s = cand_s ? IDX_W'(i) : sel_idx_s;
            found_s   = found_s | cand_s;
        end
    end

    // Next-state logic of the capture/scan/report sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = pkt_last ? ST_SELECT : ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (xfer_s && pkt_last) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_SELECT: begin
                state_nxt_s = found_s ? ST_CLEAR : ST_REPORT;
            end
            ST_CLEAR: begin
                state_nxt_s = ST_REPLAY;
            end
            ST_REPLAY: begin
                if (cmp_match) begin
                    state_nxt_s = ST_REPORT;
                end else if (last_word_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_REPLAY;
                end
            end
            ST_DRAIN: begin
                if (cmp_match) begin
                    state_nxt_s = ST_REPORT;
                end else if (drain_done_s) begin
                    state_nxt_s = last_entry_s ? ST_REPORT : ST_SELECT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_REPORT: begin
                state_nxt_s = res_ready ? ST_IDLE : ST_REPORT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet buffer; words past BUF_DEPTH are never written.
    always_ff @(posedge clk) begin
        if (xfer_s && (state_r == ST_IDLE)) begin
            pkt_buf_r[0] <= pkt_data;
        end else if (xfer_s && (state_r == ST_CAPTURE) && (count_r < CNT_W'(BUF_DEPTH))) begin
            pkt_buf_r[count_r[BUF_W-1:0]] <= pkt_data;
        end
    end

    // Table, pointers, latched IP under test and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IPS; i++) begin
                ip_tbl_r[i] <= 32'h0000_0000;
            end
            en_tbl_r     <= '0;
            count_r      <= '0;
            rd_ptr_r     <= '0;
            scan_ptr_r   <= '0;
            cur_idx_r    <= '0;
            drain_cnt_r  <= '0;
            ovf_r        <= 1'b0;
            flagged_ip_r <= 32'h0000_0000;
            res_hit_r    <= 1'b0;
            res_idx_r    <= '0;
            res_ovf_r    <= 1'b0;
        end else begin
            if (cfg_we) begin
                ip_tbl_r[cfg_idx] <= cfg_ip;
                en_tbl_r[cfg_idx] <= cfg_en;
            end
            if ((state_nxt_s == ST_REPORT) && (state_r != ST_REPORT)) begin
                res_ovf_r <= ovf_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        count_r <= CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (xfer_s) begin
                        if (count_r < CNT_W'(BUF_DEPTH)) begin
                            count_r <= count_r + CNT_W'(1);
                        end else begin
                            ovf_r <= 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    if (found_s) begin
                        flagged_ip_r <= ip_tbl_r[sel_idx_s];
                        cur_idx_r    <= sel_idx_s;
                    end
                end
                ST_CLEAR: begin
                    rd_ptr_r    <= '0;
                    drain_cnt_r <= '0;
                end
                ST_REPLAY: begin
                    rd_ptr_r <= rd_ptr_r + CNT_W'(1);
                    if (cmp_match) begin
                        res_hit_r <= 1'b1;
                        res_idx_r <= cur_idx_r;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_r <= drain_cnt_r + DRN_W'(1);
                    if (cmp_match) begin
                        res_hit_r <= 1'b1;
                        res_idx_r <= cur_idx_r;
                    end else if (drain_done_s) begin
                        scan_ptr_r <= {1'b0, cur_idx_r} + SP_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        ovf_r      <= 1'b0;
                        count_r    <= '0;
                        scan_ptr_r <= '0;
                        res_hit_r  <= 1'b0;
                        res_idx_r  <= '0;
                        res_ovf_r  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_match_sched.sv
// Bench for ip_match_sched: behavioural byte-stream comparator, directed cases
// and randomized packets checked against a substring-search reference model.
module tb_ip_match_sched;

    localparam int NUM_IPS     = 4;
    localparam int BUF_DEPTH   = 16;
    localparam int CMP_LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = 2'd0;
    logic [31:0] cfg_ip = 32'h0;
    logic        cfg_en = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [31:0] pkt_data = 32'h0;
    logic        pkt_last = 1'b0;
    logic        pkt_ready;
    logic        cmp_clear;
    logic [31:0] cmp_flagged_ip;
    logic [31:0] cmp_data_in;
    logic        cmp_match;
    logic        res_valid;
    logic        res_hit;
    logic [1:0]  res_idx;
    logic        res_ovf;
    logic        res_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tbl_ip [NUM_IPS];
    logic        tbl_en [NUM_IPS];
    logic [31:0] pkt_q [$];
    logic [31:0] data_log [$];
    int          clr_pos [$];
    logic [31:0] ip_log [$];

    always #5 clk = ~clk;

    ip_match_sched #(.NUM_IPS(NUM_IPS), .BUF_DEPTH(BUF_DEPTH), .CMP_LATENCY(CMP_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_ip(cfg_ip), .cfg_en(cfg_en),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
        .cmp_clear(cmp_clear), .cmp_flagged_ip(cmp_flagged_ip), .cmp_data_in(cmp_data_in),
        .cmp_match(cmp_match),
        .res_valid(res_valid), .res_hit(res_hit), .res_idx(res_idx), .res_ovf(res_ovf),
        .res_ready(res_ready)
    );

    // Comparator stand-in: finds the flagged IP anywhere in the byte stream since the last clear.
    function automatic logic win_hit(logic [31:0] prev, logic [31:0] cur, logic [31:0] ip, logic prev_ok);
        logic [63:0] w;
        w = {prev, cur};
        win_hit = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if ((k == 4 || prev_ok) && (w[63-8*k -: 32] == ip)) win_hit = 1'b1;
        end
    endfunction

    logic [31:0]            cm_prev = 32'h0;
    logic                   cm_prev_ok = 1'b0;
    logic [CMP_LATENCY-1:0] cm_pipe = '0;
    logic                   cm_now;
    assign cm_now    = win_hit(cm_prev, cmp_data_in, cmp_flagged_ip, cm_prev_ok);
    assign cmp_match = cm_pipe[CMP_LATENCY-1];

    always @(posedge clk) begin
        if (rst || cmp_clear) begin
            cm_prev    <= 32'h0;
            cm_prev_ok <= 1'b0;
            cm_pipe    <= '0;
        end else begin
            cm_prev    <= cmp_data_in;
            cm_prev_ok <= 1'b1;
            cm_pipe    <= {cm_pipe[CMP_LATENCY-2:0], cm_now};
        end
    end

    // Monitor: log every comparator input word, plus position and IP of each clear pulse.
    always @(posedge clk) begin
        if (cmp_clear) begin
            clr_pos.push_back(data_log.size());
            ip_log.push_back(cmp_flagged_ip);
        end
        data_log.push_back(cmp_data_in);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: first enabled entry whose IP occurs in the stored bytes followed by a zero word.
    task automatic ref_scan(output logic hit, output int idx, output logic ovf);
        logic [7:0] bs [$];
        int n;
        n   = (pkt_q.size() > BUF_DEPTH) ? BUF_DEPTH : pkt_q.size();
        ovf = (pkt_q.size() > BUF_DEPTH);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < n; i++)
            for (int b = 3; b >= 0; b--) bs.push_back(pkt_q[i][8*b +: 8]);
        for (int b = 0; b < 4; b++) bs.push_back(8'h00);
        for (int e = 0; e < NUM_IPS; e++) begin
            if (tbl_en[e] && !hit) begin
                for (int p = 0; p + 4 <= bs.size(); p++) begin
                    if ({bs[p], bs[p+1], bs[p+2], bs[p+3]} == tbl_ip[e] && !hit) begin
                        hit = 1'b1;
                        idx = e;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_IPS; i++) begin
            tbl_ip[i] = 32'h0;
            tbl_en[i] = 1'b0;
        end
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] ip, input logic en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_ip = ip; cfg_en = en;
        @(negedge clk);
        cfg_we = 1'b0;
        tbl_ip[idx] = ip;
        tbl_en[idx] = en;
    endtask

    task automatic send_pkt();
        int stalls = 0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            @(negedge clk);
            if (!pkt_ready) stalls++;
            pkt_valid = 1'b1;
            pkt_data  = pkt_q[i];
            pkt_last  = (i == pkt_q.size() - 1);
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        pkt_last  = 1'b0;
        chk("pkt_ready_during_capture", 32'(stalls), 32'd0);
    endtask

    task automatic wait_result(input int hold, input logic exp_hit, input int exp_idx,
                               input logic exp_ovf, output int lat);
        logic [31:0] got_v;
        logic [31:0] exp_v;
        lat = 1;
        while (!res_valid && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("res_valid", 32'(res_valid), 32'd1);
        exp_v = {26'd0, 1'b1, exp_hit, 2'(exp_idx), exp_ovf, 1'b0};
        for (int h = 0; h < hold; h++) begin
            got_v = {26'd0, res_valid, res_hit, res_idx, res_ovf, pkt_ready};
            chk("held_result", got_v, exp_v);
            @(negedge clk);
        end
        chk("res_hit", 32'(res_hit), 32'(exp_hit));
        chk("res_idx", 32'(res_idx), 32'(exp_idx));
        chk("res_ovf", 32'(res_ovf), 32'(exp_ovf));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
        chk("pkt_ready_back", 32'(pkt_ready), 32'd1);
    endtask

    logic [7:0] alpha [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        int lat, b0, t, bad, vcnt, ridx, nw;
        logic rhit, rovf;
        logic [7:0] by [$];
        logic [31:0] w;

        // Reset and idle outputs
        do_reset();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_cmp_clear", 32'(cmp_clear), 32'd0);
        chk("rst_cmp_data", cmp_data_in, 32'h0);
        chk("rst_pkt_ready", 32'(pkt_ready), 32'd1);
        chk("rst_flagged_ip", cmp_flagged_ip, 32'h0);
        chk("rst_res_hit", 32'(res_hit), 32'd0);

        // Single hit on entry 0
        cfg_write(0, 32'hC0A80101, 1'b1);
        b0 = clr_pos.size();
        pkt_q = '{32'hC0A80101, 32'h00000000};
        send_pkt();
        wait_result(0, 1'b1, 0, 1'b0, lat);
        chk("single_clear_count", 32'(clr_pos.size() - b0), 32'd1);
        if (clr_pos.size() > b0) begin
            chk("single_replay_w0", data_log[clr_pos[b0] + 1], 32'hC0A80101);
            chk("single_replay_w1", data_log[clr_pos[b0] + 2], 32'h00000000);
            chk("single_clear_data", data_log[clr_pos[b0]], 32'h00000000);
        end

        // Scan order and early exit
        do_reset();
        cfg_write(0, 32'h0A000001, 1'b1);
        cfg_write(1, 32'h0A0A0A0A, 1'b0);
        cfg_write(2, 32'hC0A80101, 1'b1);
        cfg_write(3, 32'h0B0B0B0B, 1'b1);
        b0 = clr_pos.size();
        pkt_q = '{32'h00C0A801, 32'h01000000};
        send_pkt();
        wait_result(0, 1'b1, 2, 1'b0, lat);
        chk("scan_clear_count", 32'(clr_pos.size() - b0), 32'd2);
        if (ip_log.size() >= b0 + 2) begin
            chk("scan_ip_first", ip_log[b0], 32'h0A000001);
            chk("scan_ip_second", ip_log[b0 + 1], 32'hC0A80101);
        end

        // No enabled entries
        do_reset();
        b0 = clr_pos.size();
        pkt_q = '{32'hFFFFFFFF};
        send_pkt();
        wait_result(0, 1'b0, 0, 1'b0, lat);
        chk("noen_latency", 32'(lat), 32'd2);
        chk("noen_clear_count", 32'(clr_pos.size() - b0), 32'd0);

        // Overflow: 20 words, matching word beyond the buffer
        do_reset();
        cfg_write(0, 32'hC0A80101, 1'b1);
        pkt_q = {};
        for (int i = 0; i < 20; i++) begin
            w = {8'h11 + 8'($urandom_range(0, 3)) * 8'h11, 8'h11 + 8'($urandom_range(0, 3)) * 8'h11,
                 8'h11 + 8'($urandom_range(0, 3)) * 8'h11, 8'h11 + 8'($urandom_range(0, 3)) * 8'h11};
            pkt_q.push_back((i == 17) ? 32'hC0A80101 : w);
        end
        b0 = clr_pos.size();
        send_pkt();
        wait_result(0, 1'b0, 0, 1'b1, lat);
        chk("ovf_clear_count", 32'(clr_pos.size() - b0), 32'd1);
        if (clr_pos.size() > b0) begin
            bad = 0;
            for (int k = 0; k < BUF_DEPTH; k++)
                if (data_log[clr_pos[b0] + 1 + k] !== pkt_q[k]) bad++;
            chk("ovf_replay16", 32'(bad), 32'd0);
            chk("ovf_no_word17", data_log[clr_pos[b0] + 1 + BUF_DEPTH], 32'h0);
        end

        // Backpressure and config write during replay of entry 0
        do_reset();
        cfg_write(0, 32'h11223344, 1'b1);
        b0 = clr_pos.size();
        pkt_q = '{32'hAABBCCDD, 32'h55667788, 32'h99AABBCC};
        send_pkt();
        t = 0;
        while (!cmp_clear && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_clear_seen", 32'(cmp_clear), 32'd1);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_ip = 32'h55667788; cfg_en = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        tbl_ip[1] = 32'h55667788;
        tbl_en[1] = 1'b1;
        chk("bp_ip_latched", cmp_flagged_ip, 32'h11223344);
        wait_result(5, 1'b1, 1, 1'b0, lat);
        if (ip_log.size() >= b0 + 2) begin
            chk("bp_ip_entry0", ip_log[b0], 32'h11223344);
            chk("bp_ip_entry1", ip_log[b0 + 1], 32'h55667788);
        end

        // Reset mid-scan: no result, table wiped
        cfg_write(0, 32'hAABBCCDD, 1'b1);
        pkt_q = '{32'h01020304, 32'hAABBCCDD};
        send_pkt();
        t = 0;
        while (!cmp_clear && t < 20) begin
            @(negedge clk);
            t++;
        end
        do_reset();
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) vcnt++;
        end
        chk("midrst_no_result", 32'(vcnt), 32'd0);
        send_pkt();
        wait_result(0, 1'b0, 0, 1'b0, lat);

        // Randomized packets against the reference model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if (it % 5 == 0) begin
                for (int e = 0; e < NUM_IPS; e++) begin
                    if ($urandom_range(0, 1) == 1)
                        cfg_write(e, {alpha[$urandom_range(0, 3)], alpha[$urandom_range(0, 3)],
                                      alpha[$urandom_range(0, 3)], alpha[$urandom_range(0, 3)]},
                                  1'($urandom_range(0, 1)));
                end
            end
            nw = $urandom_range(1, 20);
            by = {};
            for (int i = 0; i < 4 * nw; i++) by.push_back(alpha[$urandom_range(0, 3)]);
            if ($urandom_range(0, 1) == 1) begin
                t = $urandom_range(0, 4 * nw - 4);
                w = tbl_ip[$urandom_range(0, NUM_IPS - 1)];
                for (int b = 0; b < 4; b++) by[t + b] = w[31 - 8*b -: 8];
            end
            pkt_q = {};
            for (int i = 0; i < nw; i++) pkt_q.push_back({by[4*i], by[4*i+1], by[4*i+2], by[4*i+3]});
            ref_scan(rhit, ridx, rovf);
            send_pkt();
            wait_result($urandom_range(0, 2), rhit, ridx, rovf, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
